bcd_to_binary_seq: RTL and testbench

//  Sequential BCD-to-binary converter, the inverse of the combinational binary-to-BCD block.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_digit_adj.sv | 19 +
 rtl/bcd_to_binary_seq.sv | 137 +++++++++++++
 tb/tb_bcd_to_binary_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential BCD-to-binary converter.
// State encoding, digit geometry and a digit-legality check.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } b2b_state_t;

    localparam int         DIGIT_W = 4;
    localparam logic [3:0] BCD_ADJ = 4'd3;

    function automatic logic is_bcd_digit(input logic [DIGIT_W-1:0] d);
        return (d <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit correction: a digit that reached 8 or more after
// a right shift carried a half-ten in from above, so pull it back by 3.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] q
);

    // Conditional subtract-3 on a single digit.
    always_comb begin
        if (d >= 4'd8) begin
            q = d - BCD_ADJ;
        end else begin
            q = d;
        end
    end

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one
// shift/adjust per clock, with valid/ready handshakes on input and output.
module bcd_to_binary_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIGIT_W*DIGITS-1:0] bcd_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BIN_W-1:0]          bin_out,
    output logic                      err
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int SH_W  = BCD_W + BIN_W;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    b2b_state_t        state_r;
    b2b_state_t        state_nxt_s;
    logic [SH_W-1:0]   shift_r;
    logic [SH_W-1:0]   shifted_s;
    logic [SH_W-1:0]   adjusted_s;
    logic [BCD_W-1:0]  bcd_adj_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [BIN_W-1:0]  bin_r;
    logic              err_r;
    logic              in_err_s;
    logic              accept_s;
    logic              release_s;
    logic              last_s;

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign bin_out   = bin_r;
    assign err       = err_r;

    assign accept_s  = in_valid && (state_r == IDLE);
    assign release_s = out_ready && (state_r == DONE);
    assign last_s    = (state_r == CONV) && (cnt_r == LAST_CNT);

    assign shifted_s = shift_r >> 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (shifted_s[BIN_W + g*DIGIT_W +: DIGIT_W]),
            .q (bcd_adj_s[g*DIGIT_W +: DIGIT_W])
        );
    end

    assign adjusted_s = {bcd_adj_s, shifted_s[BIN_W-1:0]};

    // Flag any input digit outside 0..9.
    always_comb begin
        in_err_s = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_bcd_digit(bcd_in[i*DIGIT_W +: DIGIT_W])) begin
                in_err_s = 1'b1;
            end else begin
                in_err_s = in_err_s;
            end
        end
    end

    // Next-state decode for the IDLE/CONV/DONE sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = CONV;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CONV: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CONV;
                end
            end
            DONE: begin
                if (release_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, shift register, iteration counter and registered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            shift_r <= {SH_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            bin_r   <= {BIN_W{1'b0}};
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        shift_r <= {bcd_in, {BIN_W{1'b0}}};
                        err_r   <= in_err_s;
                        cnt_r   <= {CNT_W{1'b0}};
                    end
                end
                CONV: begin
                    shift_r <= adjusted_s;
                    cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    // Illegal words report zero rather than a garbage binary value.
                    if (last_s) begin
                        bin_r <= err_r ? {BIN_W{1'b0}} : adjusted_s[BIN_W-1:0];
                    end
                end
                DONE: begin
                    bin_r <= bin_r;
                end
                default: begin
                    shift_r <= {SH_W{1'b0}};
                    cnt_r   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Scoreboard bench for bcd_to_binary_seq: the driver queues expected results,
// a negedge monitor pops and compares them, and checks 10-edge latency.
module tb_bcd_to_binary_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] bcd_in;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  bin_out;
    logic        err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [10:0] exp_q[$];
    int          acc_q[$];
    logic        prev_v = 1'b0;

    bcd_to_binary_seq #(.DIGITS(3), .BIN_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [9:0] golden(input logic [11:0] w);
        int v;
        v = int'(w[11:8]) * 100 + int'(w[7:4]) * 10 + int'(w[3:0]);
        return v[9:0];
    endfunction

    // Present one word, record the expected result and the accepting edge.
    task automatic send(input logic [11:0] w, input logic [9:0] eb, input logic ee);
        int t = 0;
        @(posedge clk); #1;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end else begin
            bcd_in   = w;
            in_valid = 1'b1;
            acc_q.push_back(cyc + 1);
            exp_q.push_back({ee, eb});
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    // Monitor: latency on the rising edge of out_valid, data on handshake.
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid && !prev_v) begin
                if (acc_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    chk("latency", cyc - acc_q.pop_front(), 10);
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    logic [10:0] e;
                    e = exp_q.pop_front();
                    chk("bin_out", bin_out, e[9:0]);
                    chk("err", err, e[10]);
                    chk("in_ready_in_done", in_ready, 0);
                end
            end
            prev_v = out_valid;
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; bcd_in = 12'h000;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_bin_out", bin_out, 0);
        chk("rst_err", err, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: zero word
        send(12'h000, 10'd0, 1'b0);
        drain();

        // 2: 202 -> 0x0CA, then ready again
        send(12'h202, 10'h0CA, 1'b0);
        drain();
        chk("ready_after_202", in_ready, 1);
        chk("valid_after_202", out_valid, 0);

        // 3: legal sweep against decimal golden model
        for (int h = 0; h < 10; h++) begin
            for (int t = 0; t < 10; t++) begin
                for (int o = 0; o < 10; o++) begin
                    logic [11:0] w;
                    w = {h[3:0], t[3:0], o[3:0]};
                    send(w, golden(w), 1'b0);
                end
            end
        end
        drain();

        // 4: illegal tens digit
        send(12'h1A5, 10'd0, 1'b1);
        drain();
        send(12'hF00, 10'd0, 1'b1);
        drain();

        // 5: back-pressure with ignored input pulses
        out_ready = 1'b0;
        send(12'h999, 10'd999, 1'b0);
        begin
            int t = 0;
            while (!out_valid && t < 40) begin
                @(posedge clk); #1;
                t++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            bcd_in   = 12'h123;
            in_valid = (i % 2 == 0);
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_bin", bin_out, 999);
            chk("hold_err", err, 0);
            chk("hold_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("no_queued_word", out_valid, 0);
        end

        // 6: reset four edges into a conversion
        send(12'h777, 10'd777, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_bin_out", bin_out, 0);
        chk("midrst_err", err, 0);
        exp_q.delete();
        acc_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        send(12'h045, 10'd45, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
